// File: rtl/sprite_commit_sched.sv
// Sprite register write queue that commits batches to the engine on vblank.
// Writes are held until a vblank rising edge, then drained while blanking lasts.
module sprite_commit_sched #(
    parameter int DEPTH = 4,
    parameter int AW    = 6,
    parameter int DW    = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req_valid,
    input  logic [AW-1:0]            req_addr,
    input  logic [DW-1:0]            req_data,
    output logic                     req_ready,
    input  logic                     vblank,
    input  logic                     commit_en,
    input  logic                     flush,
    input  logic                     irq_clr,
    output logic                     eng_wr_en,
    output logic [AW-1:0]            eng_wr_addr,
    output logic [DW-1:0]            eng_wr_data,
    input  logic                     eng_ready,
    output logic                     busy,
    output logic                     overflow,
    output logic                     late,
    output logic                     irq,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;
    localparam logic [LW-1:0] FULL = LW'(DEPTH);
    localparam logic [LW-1:0] ONE  = LW'(1);

    typedef enum logic [1:0] {IDLE, ARMED, DRAIN, DONE} state_t;

    state_t            state;
    state_t            state_nx;
    logic [AW+DW-1:0]  mem [DEPTH];
    logic [PW-1:0]     wptr;
    logic [PW-1:0]     rptr;
    logic [LW-1:0]     rem;
    logic              vblank_d;
    logic              vb_rise;
    logic              do_flush;
    logic              push;
    logic              pop;
    logic              last;
    logic              late_set;

    assign vb_rise   = vblank && !vblank_d;
    assign do_flush  = flush && (state == IDLE || state == ARMED);
    assign req_ready = (level != FULL);
    assign push      = req_valid && req_ready && !do_flush;
    assign eng_wr_en = (state == DRAIN);
    assign pop       = eng_wr_en && eng_ready;
    assign last      = pop && (rem == ONE);
    assign busy      = (state == DRAIN) || (state == DONE);
    assign late_set  = (state == DRAIN) && !vblank && !last;

    // The head slot is never overwritten while occupied, so a stalled
    // write presents the same address/data until the engine takes it.
    assign {eng_wr_addr, eng_wr_data} = eng_wr_en ? mem[rptr] : '0;

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (!do_flush && commit_en && level != '0)
                    state_nx = ARMED;
            end
            ARMED: begin
                if (do_flush || !commit_en)
                    state_nx = IDLE;
                else if (vb_rise)
                    state_nx = DRAIN;
            end
            DRAIN: begin
                if (last)
                    state_nx = DONE;
                else if (!vblank)
                    state_nx = ARMED;
            end
            DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wptr] <= {req_addr, req_data};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            vblank_d <= 1'b0;
            wptr     <= '0;
            rptr     <= '0;
            level    <= '0;
            rem      <= '0;
            irq      <= 1'b0;
            overflow <= 1'b0;
            late     <= 1'b0;
        end else begin
            state    <= state_nx;
            vblank_d <= vblank;
            if (do_flush) begin
                wptr  <= '0;
                rptr  <= '0;
                level <= '0;
            end else begin
                if (push)
                    wptr <= wptr + 1'b1;
                if (pop)
                    rptr <= rptr + 1'b1;
                if (push && !pop)
                    level <= level + 1'b1;
                else if (!push && pop)
                    level <= level - 1'b1;
            end
            // Batch size is the pre-push level; later pushes wait a frame.
            if (state == ARMED && state_nx == DRAIN)
                rem <= level;
            else if (pop)
                rem <= rem - 1'b1;
            irq      <= (state == DONE) || (irq && !irq_clr);
            overflow <= (req_valid && !req_ready) || (overflow && !irq_clr);
            late     <= late_set || (late && !irq_clr);
        end
    end

endmodule

// File: tb/tb_sprite_commit_sched.sv
// Scoreboard bench for sprite_commit_sched: expected engine writes are
// queued at push time and checked as the engine accepts them.
module tb_sprite_commit_sched;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic [5:0]  req_addr;
    logic [15:0] req_data;
    logic        req_ready;
    logic        vblank;
    logic        commit_en;
    logic        flush;
    logic        irq_clr;
    logic        eng_wr_en;
    logic [5:0]  eng_wr_addr;
    logic [15:0] eng_wr_data;
    logic        eng_ready;
    logic        busy;
    logic        overflow;
    logic        late;
    logic        irq;
    logic [2:0]  level;

    int n_cmp;
    int n_fail;
    int wr_count;
    logic [21:0] exp_q[$];

    sprite_commit_sched #(.DEPTH(4), .AW(6), .DW(16)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .req_valid(req_valid),
        .req_addr(req_addr),
        .req_data(req_data),
        .req_ready(req_ready),
        .vblank(vblank),
        .commit_en(commit_en),
        .flush(flush),
        .irq_clr(irq_clr),
        .eng_wr_en(eng_wr_en),
        .eng_wr_addr(eng_wr_addr),
        .eng_wr_data(eng_wr_data),
        .eng_ready(eng_ready),
        .busy(busy),
        .overflow(overflow),
        .late(late),
        .irq(irq),
        .level(level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        logic [21:0] e;
        if (rst_n && eng_wr_en && eng_ready) begin
            wr_count++;
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL eng_write: got %h/%h required no write",
                         eng_wr_addr, eng_wr_data);
            end else begin
                e = exp_q.pop_front();
                if ({eng_wr_addr, eng_wr_data} !== e) begin
                    n_fail++;
                    $display("FAIL eng_write: got %h/%h required %h/%h",
                             eng_wr_addr, eng_wr_data, e[21:16], e[15:0]);
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [5:0] a, input logic [15:0] d,
                        input bit exp);
        req_valid = 1'b1;
        req_addr  = a;
        req_data  = d;
        if (exp)
            exp_q.push_back({a, d});
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_irq(output bit ok, output int n);
        ok = 1'b0;
        n  = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            n = i + 1;
            if (irq) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_en(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (eng_wr_en) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic finish_frame;
        @(posedge clk);
        #1;
        vblank  = 1'b0;
        irq_clr = 1'b1;
        cyc(1);
        irq_clr   = 1'b0;
        commit_en = 1'b0;
        cyc(1);
    endtask

    task automatic test_reset;
        #3;
        n_cmp++;
        if ({req_ready, eng_wr_en, busy, irq, overflow, late} !== 6'b100000) begin
            n_fail++;
            $display("FAIL reset_flags: got %b required 100000",
                     {req_ready, eng_wr_en, busy, irq, overflow, late});
        end
        n_cmp++;
        if ({level, eng_wr_addr, eng_wr_data} !== '0) begin
            n_fail++;
            $display("FAIL reset_vals: got %h/%h/%h required 0",
                     level, eng_wr_addr, eng_wr_data);
        end
        cyc(2);
        rst_n = 1'b1;
        cyc(1);
    endtask

    task automatic test_basic;
        int base;
        int n;
        bit ok;
        base = wr_count;
        push(6'h04, 16'h1234, 1);
        push(6'h06, 16'hAAAA, 1);
        push(6'h08, 16'h5555, 1);
        commit_en = 1'b1;
        eng_ready = 1'b1;
        cyc(2);
        vblank = 1'b1;
        wait_irq(ok, n);
        n_cmp++;
        if (!ok || n != 6) begin
            n_fail++;
            $display("FAIL basic_irq: got ok=%0d after %0d required 6", ok, n);
        end
        n_cmp++;
        if (wr_count - base != 3) begin
            n_fail++;
            $display("FAIL basic_writes: got %0d required 3", wr_count - base);
        end
        n_cmp++;
        if (level !== 3'd0) begin
            n_fail++;
            $display("FAIL basic_level: got %0d required 0", level);
        end
        finish_frame();
        @(negedge clk);
        n_cmp++;
        if (irq !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_irq_clr: got %b required 0", irq);
        end
    endtask

    task automatic test_overflow;
        for (int i = 0; i < 4; i++)
            push(6'(i), 16'(i), 0);
        @(negedge clk);
        n_cmp++;
        if (req_ready !== 1'b0 || level !== 3'd4) begin
            n_fail++;
            $display("FAIL full: got ready=%b level=%0d required 0/4",
                     req_ready, level);
        end
        @(posedge clk);
        #1;
        push(6'h3F, 16'hFFFF, 0);
        @(negedge clk);
        n_cmp++;
        if (overflow !== 1'b1 || level !== 3'd4) begin
            n_fail++;
            $display("FAIL overflow: got ovf=%b level=%0d required 1/4",
                     overflow, level);
        end
        @(posedge clk);
        #1;
        irq_clr = 1'b1;
        cyc(1);
        irq_clr = 1'b0;
        flush   = 1'b1;
        cyc(1);
        flush = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (overflow !== 1'b0 || level !== 3'd0) begin
            n_fail++;
            $display("FAIL ovf_clr: got ovf=%b level=%0d required 0/0",
                     overflow, level);
        end
        cyc(1);
    endtask

    task automatic test_stall;
        int base;
        int n;
        bit ok;
        base      = wr_count;
        eng_ready = 1'b0;
        push(6'h10, 16'hBEEF, 1);
        push(6'h12, 16'hCAFE, 1);
        commit_en = 1'b1;
        cyc(2);
        vblank = 1'b1;
        wait_en(ok);
        n_cmp++;
        if (!ok) begin
            n_fail++;
            $display("FAIL stall_start: got no eng_wr_en required 1");
        end
        for (int i = 0; i < 3; i++) begin
            if (i > 0)
                @(negedge clk);
            n_cmp++;
            if ({eng_wr_en, eng_wr_addr, eng_wr_data} !== {1'b1, 6'h10, 16'hBEEF}) begin
                n_fail++;
                $display("FAIL stall_hold%0d: got %b %h/%h required 1 10/beef",
                         i, eng_wr_en, eng_wr_addr, eng_wr_data);
            end
        end
        eng_ready = 1'b1;
        wait_irq(ok, n);
        n_cmp++;
        if (!ok || wr_count - base != 2) begin
            n_fail++;
            $display("FAIL stall_done: got irq=%b writes=%0d required 1/2",
                     ok, wr_count - base);
        end
        finish_frame();
    endtask

    task automatic test_late;
        int base;
        int k;
        int n;
        bit ok;
        base = wr_count;
        k    = 0;
        for (int i = 0; i < 4; i++)
            push(6'(8'h20 + i), 16'(16'h1000 + i), 1);
        commit_en = 1'b1;
        eng_ready = 1'b1;
        cyc(2);
        vblank = 1'b1;
        for (int i = 0; i < 20 && k < 2; i++) begin
            @(negedge clk);
            if (eng_wr_en && eng_ready)
                k++;
        end
        @(posedge clk);
        #1;
        eng_ready = 1'b0;
        vblank    = 1'b0;
        @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if ({late, busy, eng_wr_en} !== 3'b100 || level !== 3'd2) begin
            n_fail++;
            $display("FAIL late: got late/busy/en=%b level=%0d required 100/2",
                     {late, busy, eng_wr_en}, level);
        end
        cyc(2);
        eng_ready = 1'b1;
        vblank    = 1'b1;
        wait_irq(ok, n);
        n_cmp++;
        if (!ok || wr_count - base != 4 || level !== 3'd0) begin
            n_fail++;
            $display("FAIL late_resume: got irq=%b writes=%0d level=%0d required 1/4/0",
                     ok, wr_count - base, level);
        end
        finish_frame();
        @(negedge clk);
        n_cmp++;
        if (late !== 1'b0) begin
            n_fail++;
            $display("FAIL late_clr: got %b required 0", late);
        end
    endtask

    task automatic test_push_in_drain;
        int base;
        int n;
        bit ok;
        base      = wr_count;
        eng_ready = 1'b0;
        push(6'h30, 16'h0101, 1);
        push(6'h32, 16'h0202, 1);
        commit_en = 1'b1;
        cyc(2);
        vblank = 1'b1;
        wait_en(ok);
        @(posedge clk);
        #1;
        push(6'h34, 16'h0303, 1);
        eng_ready = 1'b1;
        wait_irq(ok, n);
        n_cmp++;
        if (!ok || wr_count - base != 2 || level !== 3'd1) begin
            n_fail++;
            $display("FAIL drain_push: got irq=%b writes=%0d level=%0d required 1/2/1",
                     ok, wr_count - base, level);
        end
        @(posedge clk);
        #1;
        vblank  = 1'b0;
        irq_clr = 1'b1;
        cyc(1);
        irq_clr = 1'b0;
        cyc(3);
        vblank = 1'b1;
        wait_irq(ok, n);
        n_cmp++;
        if (!ok || wr_count - base != 3 || level !== 3'd0) begin
            n_fail++;
            $display("FAIL rearm: got irq=%b writes=%0d level=%0d required 1/3/0",
                     ok, wr_count - base, level);
        end
        finish_frame();
    endtask

    task automatic test_reset_mid_drain;
        int base;
        bit ok;
        eng_ready = 1'b0;
        push(6'h3A, 16'h7777, 1);
        push(6'h3B, 16'h8888, 1);
        push(6'h3C, 16'h9999, 1);
        commit_en = 1'b1;
        cyc(2);
        vblank = 1'b1;
        wait_en(ok);
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({ok, eng_wr_en, busy} !== 3'b100 || level !== 3'd0) begin
            n_fail++;
            $display("FAIL rst_drain: got ok/en/busy=%b level=%0d required 100/0",
                     {ok, eng_wr_en, busy}, level);
        end
        exp_q.delete();
        eng_ready = 1'b1;
        vblank    = 1'b0;
        commit_en = 1'b0;
        #10;
        rst_n = 1'b1;
        base  = wr_count;
        cyc(5);
        n_cmp++;
        if (wr_count != base || level !== 3'd0) begin
            n_fail++;
            $display("FAIL rst_after: got writes=%0d level=%0d required 0/0",
                     wr_count - base, level);
        end
    endtask

    task automatic test_flush_armed;
        int base;
        for (int i = 0; i < 3; i++)
            push(6'(8'h11 + i), 16'(16'h4000 + i), 0);
        commit_en = 1'b1;
        cyc(2);
        flush = 1'b1;
        cyc(1);
        flush = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (level !== 3'd0 || req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL flush: got level=%0d ready=%b required 0/1",
                     level, req_ready);
        end
        base = wr_count;
        @(posedge clk);
        #1;
        vblank = 1'b1;
        cyc(6);
        n_cmp++;
        if (wr_count != base || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_idle: got writes=%0d busy=%b required 0/0",
                     wr_count - base, busy);
        end
        vblank    = 1'b0;
        commit_en = 1'b0;
        cyc(1);
    endtask

    initial begin
        n_cmp     = 0;
        n_fail    = 0;
        wr_count  = 0;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_addr  = '0;
        req_data  = '0;
        vblank    = 1'b0;
        commit_en = 1'b0;
        flush     = 1'b0;
        irq_clr   = 1'b0;
        eng_ready = 1'b0;
        test_reset();
        test_basic();
        test_overflow();
        test_stall();
        test_late();
        test_push_in_drain();
        test_reset_mid_drain();
        test_flush_armed();
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_empty: got %0d left required 0",
                     exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/sprite_commit_sched.md
SPRITE_COMMIT_SCHED -- requirements
Module: sprite_commit_sched

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning write-queue entries (power of two, >=2).
REQ-002 SHALL have parameter AW, default 6, meaning sprite-engine register address width.
REQ-003 SHALL have parameter DW, default 16, meaning register write data width.
REQ-004 SHALL have port clk  input  1  the single clock.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-006 SHALL have ports req_valid/req_addr/req_data  input  1/AW/DW  CPU register write offered to the queue.
REQ-007 SHALL have port req_ready  output  1  queue not full (push accepted when req_valid && req_ready).
REQ-008 SHALL have port vblank  input  1  level, high during vertical blanking, already synchronous to clk.
REQ-009 SHALL have ports commit_en, flush, irq_clr  input  1 each  commit arm enable, queue discard, interrupt clear.
REQ-010 SHALL have ports eng_wr_en/eng_wr_addr/eng_wr_data  output  1/AW/DW  write toward sprite engine registers.
REQ-011 SHALL have port eng_ready  input  1  engine accepts the write this cycle.
REQ-012 SHALL have ports busy, overflow, late, irq  output  1 each; level  output  log2(DEPTH)+1  entries queued.

Function
REQ-013 SHALL implement a FIFO of {addr,data}; push on req_valid&&req_ready, pop on eng_wr_en&&eng_ready; simultaneous push/pop leaves level unchanged.
REQ-014 SHALL drive req_ready = (level != DEPTH); req_valid while full SHALL drop the write and set sticky overflow.
REQ-015 SHALL detect vblank rising edge with a registered vblank_d (vb_rise = vblank && !vblank_d).
REQ-016 SHALL implement states IDLE, ARMED, DRAIN, DONE.
REQ-017 IDLE -> ARMED when commit_en && level != 0.
REQ-018 ARMED -> IDLE when !commit_en; ARMED -> DRAIN on vb_rise; vblank already high on arming SHALL wait for the next rising edge.
REQ-019 On entering DRAIN, SHALL latch batch = level (pre-push value); only batch entries are drained, pushes during DRAIN remain for next frame.
REQ-020 In DRAIN, eng_wr_en = 1 with head entry; addr/data SHALL stay stable while eng_wr_en && !eng_ready.
REQ-021 DRAIN -> DONE in the cycle the batch-th write is accepted; commit_en deassert SHALL NOT abort DRAIN.
REQ-022 If vblank falls in DRAIN before batch completes: no further writes issued after that cycle, set sticky late, go to ARMED (remainder waits for next vb_rise).
REQ-023 DONE lasts one cycle, sets irq, then -> IDLE (re-arms next cycle if entries remain and commit_en).
REQ-024 irq SHALL be sticky, cleared by irq_clr; set wins over simultaneous clear; irq_clr also clears overflow and late.
REQ-025 flush in IDLE/ARMED SHALL empty FIFO and return to IDLE; flush in DRAIN/DONE SHALL be ignored; a push coinciding with flush is discarded.
REQ-026 busy = (state == DRAIN || state == DONE); eng_wr_en SHALL be 0 outside DRAIN.
REQ-027 FIFO pointers SHALL wrap modulo DEPTH; level SHALL never exceed DEPTH.

Reset
REQ-028 rst_n low SHALL immediately force state IDLE, FIFO empty, level 0, req_ready 1, eng_wr_en 0, busy/irq/overflow/late 0, vblank_d 0.
REQ-029 Reset asserted mid-DRAIN SHALL discard all queued entries with no further engine writes.
REQ-030 eng_wr_addr/eng_wr_data SHALL reset to 0.

Verification
REQ-031 Push 3 writes (0x04/0x1234, 0x06/0xAAAA, 0x08/0x5555), commit_en=1, eng_ready=1, vblank rise -> 3 consecutive eng writes in order, then irq=1, level=0.
REQ-032 Push 5 writes with DEPTH=4 -> 5th dropped, overflow=1, req_ready=0 at level 4; irq_clr -> overflow=0.
REQ-033 Drain 2 entries with eng_ready low 3 cycles on first -> eng_wr_addr/data held 3 cycles, both writes delivered, irq set.
REQ-034 Batch of 4, vblank falls after 2 accepted -> late=1, level=2, state ARMED; next vb_rise drains remaining 2.
REQ-035 Push during DRAIN of batch 2 -> only 2 writes issued this frame, level=1 after DONE, re-arms.
REQ-036 Assert rst_n low mid-DRAIN -> eng_wr_en=0 same cycle, level=0; flush in ARMED with 3 queued -> level=0, IDLE.
